// File: rtl/reg_bank_writer_if.sv
// reg_bank_writer_if: shared-bus write channel (data, destination, 4-phase req/ack)
interface reg_bank_writer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] inBus;
    logic [2:0]       Dst;
    logic             WrReq;
    logic             WrAck;

    modport master (output inBus, Dst, WrReq, input WrAck);
    modport slave  (input inBus, Dst, WrReq, output WrAck);
endinterface

// File: rtl/reg_bank_writer.sv
// reg_bank_writer: 4-phase handshake writer into an 8-entry register bank with commit counter
module reg_bank_writer #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             Clk,
    input  logic             Resetn,
    reg_bank_writer_if.slave bus,
    input  logic             Clear,
    output logic             Busy,
    output logic [7:0]       WrCount,
    output logic [WIDTH-1:0] outR0,
    output logic [WIDTH-1:0] outR1,
    output logic [WIDTH-1:0] outR2,
    output logic [WIDTH-1:0] outR3,
    output logic [WIDTH-1:0] outR4,
    output logic [WIDTH-1:0] outR5,
    output logic [WIDTH-1:0] outR6,
    output logic [WIDTH-1:0] outR7
);
    typedef enum logic [1:0] {IDLE, LOAD, ACK} state_t;

    state_t           state, next;
    logic [WIDTH-1:0] hold_data;
    logic [2:0]       hold_dst;
    logic [WIDTH-1:0] r [8];

    // state register
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) state <= IDLE;
        else         state <= next;
    end

    // next state: LOAD always commits in one edge; ACK waits for the request to drop
    always_comb begin
        next = (state == IDLE) ? (bus.WrReq ? LOAD : IDLE) :
               (state == LOAD) ? ACK :
                                 (bus.WrReq ? ACK : IDLE);
    end

    // capture bus data and destination so later bus activity cannot disturb the pending write
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            hold_data <= '0;
            hold_dst  <= '0;
        end else if (state == IDLE && bus.WrReq) begin
            hold_data <= bus.inBus;
            hold_dst  <= bus.Dst;
        end
    end

    // register bank and commit counter; Clear overrides a coincident commit
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < 8; i++) r[i] <= RESET_VAL;
            WrCount <= '0;
        end else if (Clear) begin
            for (int i = 0; i < 8; i++) r[i] <= RESET_VAL;
            WrCount <= '0;
        end else if (state == LOAD) begin
            r[hold_dst] <= hold_data;
            WrCount     <= WrCount + 8'd1;
        end
    end

    assign Busy      = state != IDLE;
    assign bus.WrAck = state == ACK;
    assign outR0     = r[0];
    assign outR1     = r[1];
    assign outR2     = r[2];
    assign outR3     = r[3];
    assign outR4     = r[4];
    assign outR5     = r[5];
    assign outR6     = r[6];
    assign outR7     = r[7];
endmodule

// File: tb/tb_reg_bank_writer.sv
// tb_reg_bank_writer: directed scoreboard bench for reg_bank_writer
module tb_reg_bank_writer;
    typedef struct {
        logic [2:0]  dst;
        logic [15:0] data;
        logic [7:0]  cnt;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Resetn;
    logic        Clear;
    logic        Busy;
    logic [7:0]  WrCount;
    logic [15:0] o [8];
    logic [15:0] mr [8];
    logic [7:0]  mc;
    exp_t        sb [$];
    int          total = 0;
    int          bad = 0;

    reg_bank_writer_if #(.WIDTH(16)) bus ();

    reg_bank_writer #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
        .Clk(Clk), .Resetn(Resetn), .bus(bus), .Clear(Clear), .Busy(Busy), .WrCount(WrCount),
        .outR0(o[0]), .outR1(o[1]), .outR2(o[2]), .outR3(o[3]),
        .outR4(o[4]), .outR5(o[5]), .outR6(o[6]), .outR7(o[7])
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bank(input string tag);
        for (int k = 0; k < 8; k++) chk(tag, 32'(o[k]), 32'(mr[k]));
    endtask

    // one full 4-phase write; clr asserts Clear on the commit edge
    task automatic wr(input logic [2:0] d, input logic [15:0] v, input int hold, input bit clr);
        exp_t e;
        int n;
        bus.Dst = d;
        bus.inBus = v;
        bus.WrReq = 1'b1;
        if (clr) begin
            for (int k = 0; k < 8; k++) mr[k] = 16'h0000;
            mc = 8'd0;
        end else begin
            mr[d] = v;
            mc = mc + 8'd1;
        end
        sb.push_back('{d, mr[d], mc});
        step();
        chk("busy_load", 32'(Busy), 32'd1);
        chk("ack_load", 32'(bus.WrAck), 32'd0);
        bus.inBus = 16'hFFFF;
        bus.Dst = d ^ 3'd7;
        Clear = clr;
        step();
        Clear = 1'b0;
        n = 0;
        while (bus.WrAck !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk("ack_latency", 32'(n), 32'd0);
        e = sb.pop_front();
        chk("dst_reg", 32'(o[e.dst]), 32'(e.data));
        chk("count", 32'(WrCount), 32'(e.cnt));
        chk_bank("bank");
        for (int i = 0; i < hold; i++) begin
            step();
            chk("ack_held", 32'(bus.WrAck), 32'd1);
            chk("cnt_held", 32'(WrCount), 32'(mc));
        end
        bus.WrReq = 1'b0;
        step();
        chk("ack_drop", 32'(bus.WrAck), 32'd0);
        chk("busy_idle", 32'(Busy), 32'd0);
        chk("cnt_after", 32'(WrCount), 32'(mc));
    endtask

    initial begin
        Resetn = 1'b0;
        Clear = 1'b0;
        bus.WrReq = 1'b0;
        bus.Dst = 3'd0;
        bus.inBus = 16'h0000;
        for (int k = 0; k < 8; k++) mr[k] = 16'h0000;
        mc = 8'd0;
        #3;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_ack", 32'(bus.WrAck), 32'd0);
        chk("rst_cnt", 32'(WrCount), 32'd0);
        chk_bank("rst_bank");
        step();
        step();
        Resetn = 1'b1;
        wr(3'd5, 16'hA5A5, 2, 1'b0);
        wr(3'd3, 16'hBEEF, 10, 1'b0);
        wr(3'd2, 16'h1234, 0, 1'b1);
        wr(3'd6, 16'h0F0F, 0, 1'b0);
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        for (int k = 0; k < 8; k++) mr[k] = 16'h0000;
        mc = 8'd0;
        chk("clr_idle_cnt", 32'(WrCount), 32'd0);
        chk_bank("clr_idle_bank");
        for (int i = 0; i < 256; i++) wr(3'd7, 16'(i), 0, 1'b0);
        chk("wrap_cnt", 32'(WrCount), 32'd0);
        chk("wrap_r7", 32'(o[7]), 32'h00FF);
        bus.Dst = 3'd4;
        bus.inBus = 16'h7777;
        bus.WrReq = 1'b1;
        step();
        chk("mid_busy", 32'(Busy), 32'd1);
        #2;
        Resetn = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) mr[k] = 16'h0000;
        mc = 8'd0;
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        chk("mid_rst_ack", 32'(bus.WrAck), 32'd0);
        chk("mid_rst_cnt", 32'(WrCount), 32'd0);
        chk_bank("mid_rst_bank");
        bus.WrReq = 1'b0;
        step();
        step();
        chk("mid_no_write", 32'(o[4]), 32'h0000);
        Resetn = 1'b1;
        wr(3'd1, 16'hCAFE, 1, 1'b0);
        chk("post_rst_cnt", 32'(WrCount), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
